mult_arbiter: RTL



---
 rtl/mult_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer sharing one external 4x4 combinational multiplier
// between two valid/ready requesters, returning id-tagged registered products.
// Optional per-requester saturating grant counters are built when MULT_ARB_STATS_EN is defined.
module mult_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_a0,
    input  logic [3:0]       req_b0,
    input  logic [3:0]       req_a1,
    input  logic [3:0]       req_b1,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_p,
    output logic             rsp_id,
    output logic             busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic [3:0] r_op_a;
    logic [3:0] r_op_b;
    logic       r_id;
    logic       r_last_id;
    logic [7:0] r_rsp_p;
    logic       r_rsp_id;
    logic       r_rsp_valid;
    logic       w_grant;
    logic       w_accept;

    // Winner: a lone valid requester, otherwise the one not granted last.
    always_comb begin
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_id;
        end else begin
            w_grant = req_valid[1];
        end
    end

    // No handshake is offered while reset is held, even though the state reads IDLE.
    assign w_accept = rst_n && (r_state == StIdle) && (req_valid != 2'b00);

    // Next-state logic plus the combinational ready and multiplier operand outputs.
    always_comb begin
        w_state_d = r_state;
        req_ready = 2'b00;
        mul_a     = 4'd0;
        mul_b     = 4'd0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    req_ready = w_grant ? 2'b10 : 2'b01;
                    w_state_d = StCalc;
                end
            end
            StCalc: begin
                // Operands come straight from registers so the multiplier sees clean inputs.
                mul_a     = r_op_a;
                mul_b     = r_op_b;
                w_state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, captured operands, arbitration history and the response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op_a      <= 4'd0;
            r_op_b      <= 4'd0;
            r_id        <= 1'b0;
            r_last_id   <= 1'b1;
            r_rsp_p     <= 8'h00;
            r_rsp_id    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_op_a    <= w_grant ? req_a1 : req_a0;
                r_op_b    <= w_grant ? req_b1 : req_b0;
                r_id      <= w_grant;
                r_last_id <= w_grant;
            end
            if (r_state == StCalc) begin
                r_rsp_p     <= mul_p;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == StResp) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_p     = r_rsp_p;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != StIdle);

`ifdef MULT_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Saturating per-requester grant counters, bumped on each accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_grant && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_grant && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`else
    // Counter width is meaningless without the counters.
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule
